// File: rtl/cby_pipe_tile.sv
// Y connection-block tile for empty grid columns: vertical channel pass-through
// with a per-track, per-direction retiming delay of 0..PIPE_DEPTH clock stages.
// Delays are selected by a serial configuration chain (ccff_head -> ccff_tail).
module cby_pipe_tile #(
    parameter int unsigned CHAN_WIDTH = 32,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  config_enable,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    input  logic [0:CHAN_WIDTH-1] chany_bottom_in,
    input  logic [0:CHAN_WIDTH-1] chany_top_in,
    output logic [0:CHAN_WIDTH-1] chany_top_out,
    output logic [0:CHAN_WIDTH-1] chany_bottom_out
);

    localparam int unsigned SEL_W = $clog2(PIPE_DEPTH + 1);
    localparam int unsigned CFG_L = 2 * CHAN_WIDTH * SEL_W;

    // Configuration chain: cfg_q[0] is the head end, cfg_q[CFG_L-1] the tail end.
    logic [0:CFG_L-1] cfg_q;
    logic [0:CFG_L-1] cfg_d;

    // Per-track delay lines; bit j of a track holds its input delayed by j+1 cycles.
    logic [CHAN_WIDTH-1:0][PIPE_DEPTH-1:0] up_q;
    logic [CHAN_WIDTH-1:0][PIPE_DEPTH-1:0] up_d;
    logic [CHAN_WIDTH-1:0][PIPE_DEPTH-1:0] dn_q;
    logic [CHAN_WIDTH-1:0][PIPE_DEPTH-1:0] dn_d;

    // Clamp an out-of-range delay field to the deepest available stage.
    function automatic logic [SEL_W-1:0] sat_sel(input logic [SEL_W-1:0] field);
        if (field > SEL_W'(PIPE_DEPTH)) begin
            return SEL_W'(PIPE_DEPTH);
        end
        return field;
    endfunction

    // Chain shifts one position toward the tail while config_enable is high.
    always_comb begin
        cfg_d = cfg_q;
        if (config_enable) begin
            cfg_d = {ccff_head, cfg_q[0:CFG_L-2]};
        end
    end

    assign ccff_tail = cfg_q[CFG_L-1];

    for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_track
        logic [SEL_W-1:0]  top_sel;
        logic [SEL_W-1:0]  bot_sel;
        logic [PIPE_DEPTH:0] up_tap;
        logic [PIPE_DEPTH:0] dn_tap;

        // Fields are read MSB-first from the chain; bottom_out fields follow all top_out fields.
        assign top_sel = sat_sel(cfg_q[i*SEL_W +: SEL_W]);
        assign bot_sel = sat_sel(cfg_q[(CHAN_WIDTH+i)*SEL_W +: SEL_W]);

        // Tap vector: bit 0 is the live input, bit k the input k cycles ago.
        assign up_tap = {up_q[i], chany_bottom_in[i]};
        assign dn_tap = {dn_q[i], chany_top_in[i]};

        // Advance each delay line by one stage every cycle, regardless of config_enable.
        assign up_d[i] = up_tap[PIPE_DEPTH-1:0];
        assign dn_d[i] = dn_tap[PIPE_DEPTH-1:0];

        // Outputs are forced low while the chain is being loaded.
        assign chany_top_out[i]    = up_tap[top_sel] & ~config_enable;
        assign chany_bottom_out[i] = dn_tap[bot_sel] & ~config_enable;
    end

    // State registers: reset clears config (all-bypass) and delay history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
        end else begin
            cfg_q <= cfg_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
        end
    end

endmodule
